// File: rtl/timer_pkg.sv
// rtl/timer_pkg.sv - shared constants and helpers for the countdown timer
package timer_pkg;

   localparam int BCD_W = 4;

   typedef logic [1:0] state_t;

   localparam state_t ST_RUN   = 2'b00;
   localparam state_t ST_PAUSE = 2'b01;
   localparam state_t ST_SET   = 2'b10;
   localparam state_t ST_FIN   = 2'b11;

   // Odd digits below the top one are tens of seconds/minutes and count 0..5.
   function automatic logic [BCD_W-1:0] digit_radix(input int i, input int digits);
      if ((i % 2 == 1) && (i < digits - 1)) begin
         return 4'd6;
      end
      return 4'd10;
   endfunction

endpackage

// File: rtl/button_debounce.sv
// rtl/button_debounce.sv - synchroniser, stability filter and press pulse for one button
module button_debounce
   import timer_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 500000
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_raw,
   output logic level,
   output logic press
);

   localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             r_sync0;
   logic             r_sync1;
   logic             r_level;
   logic             r_level_q;
   logic             r_press;
   logic [CNT_W-1:0] r_cnt;

   // Two-flop synchroniser for the asynchronous button input.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sync0 <= 1'b0;
         r_sync1 <= 1'b0;
      end else begin
         r_sync0 <= btn_raw;
         r_sync1 <= r_sync0;
      end
   end

   // Accept a new level only after DEBOUNCE_CYCLES consecutive samples disagree with it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_level <= 1'b0;
         r_cnt   <= '0;
      end else if (r_sync1 == r_level) begin
         r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
         r_level <= r_sync1;
         r_cnt   <= '0;
      end else begin
         r_cnt <= r_cnt + CNT_W'(1);
      end
   end

   // One-cycle pulse on an accepted rising level; releases produce nothing.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_level_q <= 1'b0;
         r_press   <= 1'b0;
      end else begin
         r_level_q <= r_level;
         r_press   <= r_level & ~r_level_q;
      end
   end

   assign level = r_level;
   assign press = r_press;

endmodule

// File: rtl/countdown_timer_ctrl.sv
// rtl/countdown_timer_ctrl.sv - button-driven BCD countdown timer controller
module countdown_timer_ctrl
   import timer_pkg::*;
#(
   parameter  int CLK_DIV         = 50000000,
   parameter  int DEBOUNCE_CYCLES = 500000,
   parameter  int DIGITS          = 4,
   localparam int SEL_W           = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    btn_up,
   input  logic                    btn_down,
   input  logic                    btn_left,
   input  logic                    btn_right,
   input  logic                    btn_action,
   output logic [BCD_W*DIGITS-1:0] time_bcd,
   output logic [1:0]              state,
   output logic [SEL_W-1:0]        digit_sel,
   output logic                    alarm
);

   localparam int TIME_W = BCD_W * DIGITS;
   localparam int PSC_W  = $clog2(CLK_DIV);
   localparam logic [PSC_W-1:0] PSC_LAST = PSC_W'(CLK_DIV - 1);
   localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(DIGITS - 1);

   logic [4:0]        w_raw;
   logic [4:0]        w_press;
   logic [4:0]        w_unused_levels;

   state_t            r_state;
   logic [TIME_W-1:0] r_time;
   logic [TIME_W-1:0] r_preset;
   logic [SEL_W-1:0]  r_sel;
   logic [PSC_W-1:0]  r_psc;
   logic              r_alarm;

   state_t            w_state_nx;
   logic [TIME_W-1:0] w_time_nx;
   logic [TIME_W-1:0] w_preset_nx;
   logic [SEL_W-1:0]  w_sel_nx;
   logic [PSC_W-1:0]  w_psc_nx;
   logic [TIME_W-1:0] w_time_dec;
   logic              w_borrow;
   logic              w_edit;
   logic              w_tick;

   logic              w_do_action;
   logic              w_do_up;
   logic              w_do_down;
   logic              w_do_left;
   logic              w_do_right;

   assign w_raw = {btn_right, btn_left, btn_down, btn_up, btn_action};

   for (genvar g = 0; g < 5; g++) begin : g_btn
      button_debounce #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_debounce (
         .clk    (clk),
         .rst    (rst),
         .btn_raw(w_raw[g]),
         .level  (w_unused_levels[g]),
         .press  (w_press[g])
      );
   end

   // Only the highest-priority press acts: action > up > down > left > right.
   assign w_do_action = w_press[0];
   assign w_do_up     = w_press[1] & ~w_press[0];
   assign w_do_down   = w_press[2] & ~|w_press[1:0];
   assign w_do_left   = w_press[3] & ~|w_press[2:0];
   assign w_do_right  = w_press[4] & ~|w_press[3:0];

   assign w_tick = (r_state == ST_RUN) && (r_psc == PSC_LAST);

   // Borrow-chain decrement of the time by one second.
   always_comb begin
      w_time_dec = r_time;
      w_borrow   = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
         if (w_borrow) begin
            if (r_time[i*BCD_W +: BCD_W] == '0) begin
               w_time_dec[i*BCD_W +: BCD_W] = digit_radix(i, DIGITS) - 4'd1;
            end else begin
               w_time_dec[i*BCD_W +: BCD_W] = r_time[i*BCD_W +: BCD_W] - 4'd1;
               w_borrow = 1'b0;
            end
         end
      end
   end

   // Next-state logic: FSM transitions, countdown and digit editing.
   always_comb begin
      w_state_nx  = r_state;
      w_time_nx   = r_time;
      w_preset_nx = r_preset;
      w_sel_nx    = r_sel;
      w_psc_nx    = r_psc;
      w_edit      = 1'b0;

      case (r_state)
         ST_RUN: begin
            if (w_tick) begin
               w_psc_nx  = '0;
               w_time_nx = w_time_dec;
               if (w_time_dec == '0) begin
                  w_state_nx = ST_FIN;
               end else if (w_do_action) begin
                  w_state_nx = ST_PAUSE;
               end
            end else begin
               w_psc_nx = r_psc + PSC_W'(1);
               if (w_do_action) begin
                  w_state_nx = ST_PAUSE;
               end
            end
         end
         ST_SET: begin
            if (w_do_action) begin
               if (r_time != '0) begin
                  w_state_nx  = ST_RUN;
                  w_preset_nx = r_time;
                  w_psc_nx    = '0;
               end
            end else begin
               w_edit = 1'b1;
            end
         end
         ST_PAUSE: begin
            if (w_do_action) begin
               w_state_nx = ST_RUN;
            end else begin
               w_edit = 1'b1;
            end
         end
         default: begin
            if (w_do_action) begin
               w_state_nx = ST_SET;
               w_time_nx  = r_preset;
            end
         end
      endcase

      if (w_edit) begin
         if (w_do_left) begin
            w_sel_nx = (r_sel == SEL_LAST) ? '0 : r_sel + SEL_W'(1);
         end
         if (w_do_right) begin
            w_sel_nx = (r_sel == '0) ? SEL_LAST : r_sel - SEL_W'(1);
         end
         for (int i = 0; i < DIGITS; i++) begin
            if (SEL_W'(i) == r_sel) begin
               if (w_do_up) begin
                  w_time_nx[i*BCD_W +: BCD_W] =
                     (r_time[i*BCD_W +: BCD_W] == digit_radix(i, DIGITS) - 4'd1) ?
                     4'd0 : r_time[i*BCD_W +: BCD_W] + 4'd1;
               end else if (w_do_down) begin
                  w_time_nx[i*BCD_W +: BCD_W] =
                     (r_time[i*BCD_W +: BCD_W] == 4'd0) ?
                     digit_radix(i, DIGITS) - 4'd1 : r_time[i*BCD_W +: BCD_W] - 4'd1;
               end
            end
         end
      end
   end

   // State and datapath registers; the alarm mirrors FINISHED without a cycle of lag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= ST_SET;
         r_time   <= '0;
         r_preset <= '0;
         r_sel    <= '0;
         r_psc    <= '0;
         r_alarm  <= 1'b0;
      end else begin
         r_state  <= w_state_nx;
         r_time   <= w_time_nx;
         r_preset <= w_preset_nx;
         r_sel    <= w_sel_nx;
         r_psc    <= w_psc_nx;
         r_alarm  <= (w_state_nx == ST_FIN);
      end
   end

   assign time_bcd  = r_time;
   assign state     = r_state;
   assign digit_sel = r_sel;
   assign alarm     = r_alarm;

endmodule

// File: tb/tb_countdown_timer_ctrl.sv
// tb/tb_countdown_timer_ctrl.sv - self-checking bench for countdown_timer_ctrl
module tb_countdown_timer_ctrl;

   localparam int CLK_DIV = 4;
   localparam int DEB     = 3;
   localparam int DIGITS  = 4;
   localparam int RADIX [4] = '{10, 6, 10, 10};

   localparam logic [4:0] B_ACT   = 5'b00001;
   localparam logic [4:0] B_UP    = 5'b00010;
   localparam logic [4:0] B_DOWN  = 5'b00100;
   localparam logic [4:0] B_LEFT  = 5'b01000;
   localparam logic [4:0] B_RIGHT = 5'b10000;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [4:0]  raw = '0;
   logic [15:0] time_bcd;
   logic [1:0]  state;
   logic [1:0]  digit_sel;
   logic        alarm;

   int n_cmp = 0;
   int n_bad = 0;

   // model of the specified behaviour
   bit m_hist [5][DEB+2];
   bit m_lvl [5];
   bit m_lvl_d [5];
   bit m_press [5];
   int m_d [4];
   int m_pre [4];
   int m_st;
   int m_sel;
   int m_psc;

   countdown_timer_ctrl #(
      .CLK_DIV        (CLK_DIV),
      .DEBOUNCE_CYCLES(DEB),
      .DIGITS         (DIGITS)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .btn_up    (raw[1]),
      .btn_down  (raw[2]),
      .btn_left  (raw[3]),
      .btn_right (raw[4]),
      .btn_action(raw[0]),
      .time_bcd  (time_bcd),
      .state     (state),
      .digit_sel (digit_sel),
      .alarm     (alarm)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic int m_secs();
      return m_d[3] * 600 + m_d[2] * 60 + m_d[1] * 10 + m_d[0];
   endfunction

   function automatic int m_time();
      return m_d[3] * 4096 + m_d[2] * 256 + m_d[1] * 16 + m_d[0];
   endfunction

   task automatic m_set_secs(input int s);
      int mm;
      int ss;
      mm = s / 60;
      ss = s % 60;
      m_d[3] = mm / 10;
      m_d[2] = mm % 10;
      m_d[1] = ss / 10;
      m_d[0] = ss % 10;
   endtask

   task automatic m_edit(input int w);
      case (w)
         1: m_d[m_sel] = (m_d[m_sel] + 1) % RADIX[m_sel];
         2: m_d[m_sel] = (m_d[m_sel] + RADIX[m_sel] - 1) % RADIX[m_sel];
         3: m_sel = (m_sel + 1) % DIGITS;
         4: m_sel = (m_sel + DIGITS - 1) % DIGITS;
         default: ;
      endcase
   endtask

   task automatic model_reset();
      for (int b = 0; b < 5; b++) begin
         for (int j = 0; j < DEB + 2; j++) m_hist[b][j] = 1'b0;
         m_lvl[b]   = 1'b0;
         m_lvl_d[b] = 1'b0;
         m_press[b] = 1'b0;
      end
      for (int i = 0; i < 4; i++) begin
         m_d[i]   = 0;
         m_pre[i] = 0;
      end
      m_st  = 2;
      m_sel = 0;
      m_psc = 0;
   endtask

   task automatic model_step();
      int win;
      int s;
      win = -1;
      for (int b = 0; b < 5; b++) if (m_press[b] && win < 0) win = b;
      s = m_secs();
      case (m_st)
         0: begin
            if (m_psc == CLK_DIV - 1) begin
               m_psc = 0;
               m_set_secs(s - 1);
               if (s - 1 == 0) m_st = 3;
               else if (win == 0) m_st = 1;
            end else begin
               m_psc++;
               if (win == 0) m_st = 1;
            end
         end
         2: begin
            if (win == 0) begin
               if (s != 0) begin
                  m_st  = 0;
                  m_pre = m_d;
                  m_psc = 0;
               end
            end else begin
               m_edit(win);
            end
         end
         1: begin
            if (win == 0) m_st = 0;
            else m_edit(win);
         end
         default: begin
            if (win == 0) begin
               m_st = 2;
               m_d  = m_pre;
            end
         end
      endcase
      // a button level is accepted once the last DEB synchronised samples agree
      for (int b = 0; b < 5; b++) begin
         bit newp;
         bit same;
         for (int j = DEB + 1; j > 0; j--) m_hist[b][j] = m_hist[b][j-1];
         m_hist[b][0] = raw[b];
         newp = m_lvl[b] & ~m_lvl_d[b];
         m_lvl_d[b] = m_lvl[b];
         same = 1'b1;
         for (int j = 3; j <= DEB + 1; j++) if (m_hist[b][j] != m_hist[b][2]) same = 1'b0;
         if (same) m_lvl[b] = m_hist[b][2];
         m_press[b] = newp;
      end
   endtask

   initial begin
      model_reset();
      forever begin
         @(posedge clk or posedge rst);
         if (rst) model_reset();
         else model_step();
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (!rst) begin
            chk("time", time_bcd, m_time());
            chk("state", state, m_st);
            chk("digit_sel", digit_sel, m_sel);
            chk("alarm", alarm, (m_st == 3));
         end
      end
   end

   task automatic lit(input string name, input logic [31:0] act, input logic [31:0] model,
                      input logic [31:0] exp);
      chk(name, act, exp);
      chk({name, "_model"}, model, exp);
   endtask

   task automatic press(input logic [4:0] mask);
      repeat (6) @(negedge clk);
      raw = mask;
      repeat (DEB + 4) @(posedge clk);
      @(negedge clk);
      raw = '0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(negedge clk);
      rst = 1'b0;
      lit("rst_time", time_bcd, m_time(), 0);
      lit("rst_state", state, m_st, 2);
      lit("rst_sel", digit_sel, m_sel, 0);
      lit("rst_alarm", alarm, m_st == 3, 0);

      // action with zero time stays in SET
      press(B_ACT);
      lit("zero_act_state", state, m_st, 2);

      // set 20:00 and run
      press(B_RIGHT);
      lit("right_wrap_sel", digit_sel, m_sel, 3);
      press(B_UP);
      press(B_UP);
      lit("set_time", time_bcd, m_time(), 16'h2000);
      press(B_ACT);
      lit("run_state", state, m_st, 0);
      lit("run_time", time_bcd, m_time(), 16'h2000);
      repeat (4) @(negedge clk);
      lit("tick1_time", time_bcd, m_time(), 16'h1959);
      repeat (4) @(negedge clk);
      lit("tick2_time", time_bcd, m_time(), 16'h1958);

      // bounce rejection
      do_reset();
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         raw[1] = (i % 2 == 0);
      end
      @(negedge clk);
      raw[1] = 1'b1;
      repeat (8) @(negedge clk);
      raw[1] = 1'b0;
      repeat (8) @(negedge clk);
      lit("bounce_time", time_bcd, m_time(), 16'h0001);

      // expiry and acknowledge
      do_reset();
      press(B_UP);
      press(B_UP);
      press(B_ACT);
      lit("exp_run_state", state, m_st, 0);
      repeat (8) @(negedge clk);
      lit("exp_time", time_bcd, m_time(), 0);
      lit("exp_state", state, m_st, 3);
      lit("exp_alarm", alarm, m_st == 3, 1);
      press(B_ACT);
      lit("ack_state", state, m_st, 2);
      lit("ack_time", time_bcd, m_time(), 16'h0002);
      lit("ack_alarm", alarm, m_st == 3, 0);

      // pause and edit, then resume with the held prescaler
      do_reset();
      press(B_UP);
      press(B_UP);
      press(B_UP);
      press(B_RIGHT);
      press(B_RIGHT);
      press(B_UP);
      press(B_RIGHT);
      press(B_RIGHT);
      lit("pe_sel", digit_sel, m_sel, 0);
      lit("pe_time", time_bcd, m_time(), 16'h0103);
      press(B_ACT);
      press(B_ACT);
      lit("pause_state", state, m_st, 1);
      lit("pause_time", time_bcd, m_time(), 16'h0100);
      press(B_DOWN);
      lit("down_wrap_time", time_bcd, m_time(), 16'h0109);
      lit("down_state", state, m_st, 1);
      press(B_ACT);
      lit("resume_state", state, m_st, 0);
      repeat (2) @(negedge clk);
      lit("resume_hold_time", time_bcd, m_time(), 16'h0109);
      @(negedge clk);
      lit("resume_tick_time", time_bcd, m_time(), 16'h0108);

      // radix-6 wrap and digit select wrap
      do_reset();
      press(B_LEFT);
      for (int i = 0; i < 5; i++) press(B_UP);
      lit("d1_five", time_bcd, m_time(), 16'h0050);
      press(B_UP);
      lit("d1_wrap", time_bcd, m_time(), 16'h0000);
      press(B_LEFT);
      press(B_LEFT);
      lit("left_sel3", digit_sel, m_sel, 3);
      press(B_LEFT);
      lit("left_wrap", digit_sel, m_sel, 0);

      // up together with action while paused: only the resume happens
      press(B_LEFT);
      press(B_LEFT);
      press(B_LEFT);
      press(B_UP);
      press(B_ACT);
      press(B_ACT);
      lit("prio_pause_time", time_bcd, m_time(), 16'h0957);
      press(B_UP | B_ACT);
      lit("prio_state", state, m_st, 0);
      lit("prio_time", time_bcd, m_time(), 16'h0957);

      // asynchronous reset mid-run
      do_reset();
      press(B_LEFT);
      press(B_UP);
      press(B_UP);
      press(B_UP);
      press(B_ACT);
      repeat (5) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      lit("arst_time", time_bcd, m_time(), 0);
      lit("arst_state", state, m_st, 2);
      lit("arst_sel", digit_sel, m_sel, 0);
      lit("arst_alarm", alarm, m_st == 3, 0);
      @(negedge clk);
      rst = 1'b0;
      repeat (10) @(negedge clk);
      lit("post_rst_state", state, m_st, 2);
      lit("post_rst_time", time_bcd, m_time(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
